// File: rtl/stream_select_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_select_mux_if
// Purpose  : Select, input-lane and output stream signals of stream_select_mux.
// Revision : 1.0
// ============================================================================
interface stream_select_mux_if #(
    parameter int NUM_SELECT = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int SELECT_WIDTH = $clog2(NUM_SELECT);

    logic                             sel_valid;
    logic                             sel_ready;
    logic [SELECT_WIDTH-1:0]          sel_data;
    logic [NUM_SELECT-1:0]            in_valid;
    logic [NUM_SELECT-1:0]            in_ready;
    logic [NUM_SELECT*DATA_WIDTH-1:0] in_data;
    logic [NUM_SELECT-1:0]            in_last;
    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_last;

    modport master (
        output sel_valid, sel_data, in_valid, in_data, in_last, out_ready,
        input  sel_ready, in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  sel_valid, sel_data, in_valid, in_data, in_last, out_ready,
        output sel_ready, in_ready, out_valid, out_data, out_last
    );
endinterface
`default_nettype wire

// File: rtl/stream_select_mux.sv
`default_nettype none
// ============================================================================
// Module   : stream_select_mux
// Purpose  : Packet-granular N:1 stream mux; one select word forwards one
//            packet through a single registered output stage.
// Revision : 1.0
// ============================================================================
module stream_select_mux #(
    parameter int NUM_SELECT = 4,
    parameter int DATA_WIDTH = 64
) (
    input  wire logic                clk,
    input  wire logic                rst,
    stream_select_mux_if.slave       bus,
    output logic [31:0]              pkt_count,
    output logic                     sel_err
);
    localparam int SELECT_WIDTH = $clog2(NUM_SELECT);
    localparam logic [SELECT_WIDTH:0] c_NUM_SELECT = (SELECT_WIDTH+1)'(NUM_SELECT);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [SELECT_WIDTH-1:0] r_cur_sel;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_out_last;
    logic [31:0]             r_pkt_count;
    logic                    r_sel_err;

    logic                    w_out_free;
    logic                    w_sel_in_range;
    logic                    w_sel_ready;
    logic [NUM_SELECT-1:0]   w_in_ready;
    logic                    w_sel_take;
    logic                    w_sel_bad;
    logic                    w_beat;
    logic [DATA_WIDTH-1:0]   w_lane_data [NUM_SELECT];

    generate
        for (genvar g = 0; g < NUM_SELECT; g++) begin : g_lane
            assign w_lane_data[g] = bus.in_data[g*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Output stage can take a beat when empty or draining this cycle.
    assign w_out_free     = !r_out_valid || bus.out_ready;
    assign w_sel_in_range = ({1'b0, bus.sel_data} < c_NUM_SELECT);

    always_comb begin
        w_state_next = r_state;
        w_sel_ready  = 1'b0;
        w_in_ready   = '0;
        w_sel_take   = 1'b0;
        w_sel_bad    = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_ready = 1'b1;
                if (bus.sel_valid) begin
                    if (w_sel_in_range) begin
                        w_sel_take   = 1'b1;
                        w_state_next = S_STREAM;
                    end else begin
                        w_sel_bad = 1'b1;
                    end
                end
            end
            S_STREAM: begin
                w_in_ready[r_cur_sel] = w_out_free;
                w_beat                = bus.in_valid[r_cur_sel] && w_out_free;
                if (w_beat && bus.in_last[r_cur_sel]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_sel   <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_pkt_count <= 32'd0;
            r_sel_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_sel_take) begin
                r_cur_sel <= bus.sel_data;
            end
            if (w_sel_bad) begin
                r_sel_err <= 1'b1;
            end
            // A reload takes priority over the drain so valid stays high.
            if (w_beat) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_lane_data[r_cur_sel];
                r_out_last  <= bus.in_last[r_cur_sel];
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (r_out_valid && bus.out_ready && r_out_last) begin
                r_pkt_count <= r_pkt_count + 32'd1;
            end
        end
    end

    assign bus.sel_ready = w_sel_ready;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign pkt_count     = r_pkt_count;
    assign sel_err       = r_sel_err;
endmodule
`default_nettype wire
